endnode_tx_credit_queue: RTL

Outbound staging stage that sits directly upstream of the endnode TX path. It buffers flits from the switch, tracks per-VC link credits returned by the far side (GRTCRED0/1 pulses), and issues one flit at a time with a start pulse. It holds the flit until the PHY manager acknowledges consumption, and reissues the flit on timeout.

---
 rtl/endnode_tx_credit_queue_if.sv | 24 ++
 rtl/endnode_tx_credit_queue.sv | 120 ++++++++++++
 2 files changed

// File: rtl/endnode_tx_credit_queue_if.sv
// rtl/endnode_tx_credit_queue_if.sv - switch-side flit input and PHY-side issue handshake
interface endnode_tx_credit_queue_if #(
    parameter int FLIT_WIDTH = 38
);
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  in_vc;
    logic                  in_last;
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] flit_tx;
    logic                  start_tx;
    logic                  packet_done_tx;
    logic                  tx_get_data;

    modport master (
        output in_flit, in_vc, in_last, in_valid, tx_get_data,
        input  in_ready, flit_tx, start_tx, packet_done_tx
    );

    modport slave (
        input  in_flit, in_vc, in_last, in_valid, tx_get_data,
        output in_ready, flit_tx, start_tx, packet_done_tx
    );
endinterface

// File: rtl/endnode_tx_credit_queue.sv
// rtl/endnode_tx_credit_queue.sv - credit-gated TX flit queue with ack wait and timeout reissue
module endnode_tx_credit_queue #(
    parameter int DEPTH      = 8,
    parameter int CREDITS    = 8,
    parameter int FLIT_WIDTH = 38,
    parameter int TIMEOUT    = 1024
) (
    input  logic                         CLK,
    input  logic                         nRST,
    endnode_tx_credit_queue_if.slave     bus,
    input  logic [1:0]                   grtcred_rx,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt0,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt1,
    output logic [7:0]                   retry_cnt,
    output logic                         cred_ovf,
    output logic                         busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CMAX     = CW'(CREDITS);
    localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                state_q, state_d;
    logic [FLIT_WIDTH-1:0] mem_flit [DEPTH];
    logic [DEPTH-1:0]      mem_vc;
    logic [DEPTH-1:0]      mem_last;
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [AW:0]           count;
    logic [TW-1:0]         timer;
    logic                  reissue_q;
    logic [CW-1:0]         cred_q [2];
    logic                  push, pop, empty, head_vc, head_ok, retry_d, issue_first;
    logic [1:0]            dec;

    assign empty        = (count == '0);
    assign bus.in_ready = (count != FULL_CNT);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state_q == WAIT) && bus.tx_get_data;
    assign head_vc      = mem_vc[rd_ptr];
    assign head_ok      = (cred_q[head_vc] != '0);

    assign bus.flit_tx        = empty ? '0 : mem_flit[rd_ptr];
    assign bus.start_tx       = (state_q == ISSUE);
    assign bus.packet_done_tx = (state_q == ISSUE) && mem_last[rd_ptr];

    // A reissue already holds its credit, so only the first issue consumes one
    assign issue_first = (state_q == ISSUE) && !reissue_q;
    assign dec[0]      = issue_first && !head_vc;
    assign dec[1]      = issue_first && head_vc;

    assign credit_cnt0 = cred_q[0];
    assign credit_cnt1 = cred_q[1];
    assign busy        = (state_q != IDLE) || !empty;

    always_comb begin
        state_d = state_q;
        retry_d = 1'b0;
        case (state_q)
            IDLE:  if (!empty && head_ok) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.tx_get_data) begin
                    state_d = IDLE;
                end else if (timer == TLAST) begin
                    state_d = ISSUE;
                    retry_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_flit[wr_ptr] <= bus.in_flit;
            mem_vc[wr_ptr]   <= bus.in_vc;
            mem_last[wr_ptr] <= bus.in_last;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            timer     <= '0;
            reissue_q <= 1'b0;
            retry_cnt <= '0;
            cred_ovf  <= 1'b0;
            cred_q[0] <= CMAX;
            cred_q[1] <= CMAX;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;

            if (state_q == ISSUE)     timer <= '0;
            else if (state_q == WAIT) timer <= timer + 1'b1;

            if (state_d == ISSUE) reissue_q <= (state_q == WAIT);
            if (retry_d && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 1'b1;

            for (int v = 0; v < 2; v++) begin
                if (grtcred_rx[v] && !dec[v]) begin
                    if (cred_q[v] == CMAX) cred_ovf  <= 1'b1;
                    else                   cred_q[v] <= cred_q[v] + 1'b1;
                end else if (dec[v] && !grtcred_rx[v]) begin
                    cred_q[v] <= cred_q[v] - 1'b1;
                end
            end
        end
    end
endmodule
